// File: rtl/adc_sequencer_pkg.sv
// Shared types and constants for the ADC scan sequencer.
package adc_sequencer_pkg;

    localparam int CHAN_W            = 5;
    localparam int DATA_W            = 12;
    localparam int MAX_CHANNELS      = 32;

    localparam int DEF_NUM_CHANNELS  = 32;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_AVG_LOG2      = 2;
    localparam int DEF_TIMEOUT       = 1023;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_SETTLE,
        ST_CONVERT,
        ST_WAIT,
        ST_EMIT
    } seq_state_t;

    // Mask of channels that physically exist; higher mask bits are ignored.
    function automatic logic [MAX_CHANNELS-1:0] valid_bits(input int n);
        logic [MAX_CHANNELS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/adc_seq_accum.sv
// Sample counter and accumulator for one channel visit; avg is the truncated mean.
// Latency: clr/add take effect on the next clock; avg and count_done are combinational views of state.
// Backpressure: none, the sequencer FSM alone decides when to add or clear.
module adc_seq_accum
    import adc_sequencer_pkg::*;
#(
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] data,
    output logic              count_done,
    output logic [DATA_W-1:0] avg
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= acc + ACC_W'(data);
            cnt <= cnt + CNT_ONE;
        end
    end

    // High while the sample being added now is the last of the set.
    assign count_done = (cnt == LAST_SAMPLE);
    assign avg        = acc[ACC_W-1 -: DATA_W];

endmodule

// File: rtl/adc_sequencer.sv
// Round-robin ADC scan: select, settle, start/wait per conversion, average, one result strobe per channel visit.
// Latency: adc_strb one cycle after the final adc_done_i; strobes are at least SETTLE_CYCLES+4 cycles apart.
// Backpressure: none; consumers must take each strobe, run=0 stops after the channel in progress.
module adc_sequencer
    import adc_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int AVG_LOG2      = DEF_AVG_LOG2,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    run,
    input  logic [MAX_CHANNELS-1:0] chan_mask,
    output logic [CHAN_W-1:0]       adc_chsel_o,
    output logic                    adc_start_o,
    input  logic                    adc_done_i,
    input  logic [DATA_W-1:0]       adc_data_i,
    output logic                    adc_strb,
    output logic [CHAN_W-1:0]       adc_channel,
    output logic [DATA_W-1:0]       adc_result,
    output logic                    conv_timeout,
    output logic                    seq_busy
);

    localparam logic [MAX_CHANNELS-1:0] VALID_MASK = valid_bits(NUM_CHANNELS);
    localparam logic [CHAN_W-1:0] LAST_CH     = CHAN_W'(NUM_CHANNELS - 1);
    localparam logic [CHAN_W-1:0] CH_ONE      = CHAN_W'(1);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0]       TMO_LIMIT   = 16'(TIMEOUT);

    seq_state_t        state, state_nxt;
    logic [CHAN_W-1:0] chsel, chsel_nxt;
    logic [CHAN_W-1:0] ptr, ptr_nxt;
    logic [CHAN_W-1:0] scnt, scnt_nxt;
    logic [7:0]        settle_cnt, settle_nxt;
    logic [15:0]       tmo_cnt, tmo_nxt;
    logic [CHAN_W-1:0] chan_q;
    logic [DATA_W-1:0] result_q;

    logic              acc_clr;
    logic              acc_add;
    logic              acc_done;
    logic [DATA_W-1:0] acc_avg;

    function automatic logic [CHAN_W-1:0] next_ch(input logic [CHAN_W-1:0] c);
        return (c == LAST_CH) ? '0 : c + CH_ONE;
    endfunction

    adc_seq_accum #(
        .AVG_LOG2   (AVG_LOG2)
    ) u_accum (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .clr        (acc_clr),
        .add        (acc_add),
        .data       (adc_data_i),
        .count_done (acc_done),
        .avg        (acc_avg)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= ST_IDLE;
            chsel      <= '0;
            ptr        <= '0;
            scnt       <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            chan_q     <= '0;
            result_q   <= '0;
        end else begin
            state      <= state_nxt;
            chsel      <= chsel_nxt;
            ptr        <= ptr_nxt;
            scnt       <= scnt_nxt;
            settle_cnt <= settle_nxt;
            tmo_cnt    <= tmo_nxt;
            if (state == ST_EMIT) begin
                chan_q   <= chsel;
                result_q <= acc_avg;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        chsel_nxt    = chsel;
        ptr_nxt      = ptr;
        scnt_nxt     = scnt;
        settle_nxt   = settle_cnt;
        tmo_nxt      = tmo_cnt;
        acc_clr      = 1'b0;
        acc_add      = 1'b0;
        adc_start_o  = 1'b0;
        conv_timeout = 1'b0;
        adc_strb     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run && |(chan_mask & VALID_MASK)) begin
                    state_nxt = ST_SEARCH;
                    ptr_nxt   = next_ch(chsel);
                    scnt_nxt  = '0;
                end
            end
            ST_SEARCH: begin
                // One channel per cycle; NUM_CHANNELS misses means the mask emptied.
                if (chan_mask[ptr]) begin
                    chsel_nxt  = ptr;
                    acc_clr    = 1'b1;
                    settle_nxt = '0;
                    state_nxt  = ST_SETTLE;
                end else if (scnt == LAST_CH) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ptr_nxt  = next_ch(ptr);
                    scnt_nxt = scnt + CH_ONE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ST_CONVERT;
                end else begin
                    settle_nxt = settle_cnt + 8'd1;
                end
            end
            ST_CONVERT: begin
                adc_start_o = 1'b1;
                tmo_nxt     = 16'd1;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                if (adc_done_i) begin
                    acc_add   = 1'b1;
                    state_nxt = acc_done ? ST_EMIT : ST_CONVERT;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    conv_timeout = 1'b1;
                    acc_clr      = 1'b1;
                    state_nxt    = run ? ST_SEARCH : ST_IDLE;
                    ptr_nxt      = next_ch(chsel);
                    scnt_nxt     = '0;
                end else begin
                    tmo_nxt = tmo_cnt + 16'd1;
                end
            end
            ST_EMIT: begin
                adc_strb  = 1'b1;
                state_nxt = run ? ST_SEARCH : ST_IDLE;
                ptr_nxt   = next_ch(chsel);
                scnt_nxt  = '0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The fresh average is shown during the strobe cycle, then held in result_q.
    assign adc_chsel_o = chsel;
    assign adc_channel = (state == ST_EMIT) ? chsel   : chan_q;
    assign adc_result  = (state == ST_EMIT) ? acc_avg : result_q;
    assign seq_busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed scan scenarios with a behavioural ADC; a scoreboard queue is checked by an independent monitor.
module tb_adc_sequencer;
    import adc_sequencer_pkg::*;

    localparam int SETTLE = 16;
    localparam int TMO    = 1023;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_n_i = 1'b0;
    logic              run = 1'b0;
    logic [31:0]       chan_mask = '0;
    logic [4:0]        adc_chsel_o;
    logic              adc_start_o;
    logic              adc_done_i = 1'b0;
    logic [11:0]       adc_data_i = '0;
    logic              adc_strb;
    logic [4:0]        adc_channel;
    logic [11:0]       adc_result;
    logic              conv_timeout;
    logic              seq_busy;

    always #5 wb_clk_i = ~wb_clk_i;

    adc_sequencer #(
        .NUM_CHANNELS  (32),
        .SETTLE_CYCLES (SETTLE),
        .AVG_LOG2      (2),
        .TIMEOUT       (TMO)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_n_i   (wb_rst_n_i),
        .run          (run),
        .chan_mask    (chan_mask),
        .adc_chsel_o  (adc_chsel_o),
        .adc_start_o  (adc_start_o),
        .adc_done_i   (adc_done_i),
        .adc_data_i   (adc_data_i),
        .adc_strb     (adc_strb),
        .adc_channel  (adc_channel),
        .adc_result   (adc_result),
        .conv_timeout (conv_timeout),
        .seq_busy     (seq_busy)
    );

    typedef struct {
        logic [4:0]  ch;
        logic [11:0] res;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int strb_cnt = 0;
    int to_cnt = 0;
    int start_cnt = 0;
    int dead_ch = -1;
    int exp_gap = 0;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ADC samples 0x100 + 16*ch + k for the k-th conversion of a visit: mean 0x101 + 16*ch after truncation.
    function automatic exp_t mk(input int ch);
        exp_t e;
        e.ch  = 5'(ch);
        e.res = 12'(12'h101 + 16 * ch);
        return e;
    endfunction

    // Behavioural ADC: done 20 cycles after start; back-to-back starts (21 apart) belong to the same visit.
    int m_cnt = 0;
    int m_prev = -1000;
    int m_k = 0;
    logic [11:0] m_data = '0;
    initial begin
        forever begin
            @(negedge wb_clk_i);
            adc_done_i = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    adc_done_i = 1'b1;
                    adc_data_i = m_data;
                end
            end
            if (adc_start_o) begin
                if (cyc - m_prev <= 22) m_k++;
                else m_k = 0;
                m_prev = cyc;
                if (int'(adc_chsel_o) != dead_ch) begin
                    m_cnt  = 20;
                    m_data = 12'(12'h100 + 16 * int'(adc_chsel_o) + m_k);
                end
            end
        end
    end

    // Monitor: samples just after each rising edge.
    logic [4:0] prev_chsel = '0;
    logic [4:0] start_chsel = '0;
    int last_chg = 0;
    int start_cyc = 0;
    int last_strb = -1000;
    bit inflight = 0;
    bit after_strb = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge wb_clk_i);
            #2;
            if (!wb_rst_n_i) begin
                inflight = 0;
                prev_chsel = adc_chsel_o;
                continue;
            end
            if (adc_chsel_o != prev_chsel) last_chg = cyc;
            prev_chsel = adc_chsel_o;
            if (adc_start_o) begin
                start_cnt++;
                check("settle_before_start", 32'((cyc - last_chg) >= SETTLE), 1);
                if (exp_gap != 0 && after_strb) check("strobe_to_start_gap", 32'(cyc - last_strb), 32'(exp_gap));
                inflight = 1;
                after_strb = 0;
                start_chsel = adc_chsel_o;
                start_cyc = cyc;
            end
            if (adc_done_i && inflight) begin
                check("chsel_stable_in_conv", 32'(adc_chsel_o), 32'(start_chsel));
                inflight = 0;
            end
            if (conv_timeout) begin
                to_cnt++;
                check("timeout_cycle", 32'(cyc - start_cyc), TMO);
                check("timeout_chan", 32'(adc_chsel_o), 32'(dead_ch));
                inflight = 0;
            end
            if (adc_strb) begin
                strb_cnt++;
                check("strobe_spacing", 32'((cyc - last_strb) >= SETTLE + 4), 1);
                last_strb = cyc;
                after_strb = 1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got ch %0d res 0x%0h, required no strobe", adc_channel, adc_result);
                end else begin
                    e = sb.pop_front();
                    check("strobe_channel", 32'(adc_channel), 32'(e.ch));
                    check("strobe_result", 32'(adc_result), 32'(e.res));
                end
            end
        end
    end

    task automatic wait_strb(input int n, input int lim);
        for (int i = 0; i < lim && strb_cnt < n; i++) @(negedge wb_clk_i);
        check("wait_strobe", 32'(strb_cnt >= n), 1);
    endtask

    task automatic wait_to(input int n, input int lim);
        for (int i = 0; i < lim && to_cnt < n; i++) @(negedge wb_clk_i);
        check("wait_timeout", 32'(to_cnt >= n), 1);
    endtask

    task automatic wait_start(input int n, input int lim);
        for (int i = 0; i < lim && start_cnt < n; i++) @(negedge wb_clk_i);
        check("wait_start", 32'(start_cnt >= n), 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && seq_busy; i++) @(negedge wb_clk_i);
        check("wait_idle", 32'(seq_busy), 0);
    endtask

    // Let the FSM leave the strobe/timeout cycle with run=1 before dropping it.
    task automatic drop_run();
        @(negedge wb_clk_i);
        run = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_chsel"},   32'(adc_chsel_o), 0);
        check({tag, "_start"},   32'(adc_start_o), 0);
        check({tag, "_strb"},    32'(adc_strb), 0);
        check({tag, "_channel"}, 32'(adc_channel), 0);
        check({tag, "_result"},  32'(adc_result), 0);
        check({tag, "_timeout"}, 32'(conv_timeout), 0);
        check({tag, "_busy"},    32'(seq_busy), 0);
    endtask

    initial begin
        int bs, bt, bst;
        repeat (3) @(negedge wb_clk_i);
        check_outputs_zero("reset");
        wb_rst_n_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);

        // Two channels alternate starting from channel 0+1.
        sb.push_back(mk(2)); sb.push_back(mk(0)); sb.push_back(mk(2)); sb.push_back(mk(0));
        bs = strb_cnt;
        chan_mask = 32'h0000_0005;
        run = 1'b1;
        wait_strb(bs + 3, 2000);
        drop_run();
        wait_idle(500);
        check("alt_strobe_count", 32'(strb_cnt - bs), 4);

        // Single channel 31: 1 emit + 32 search + 16 settle cycles to the next start.
        sb.push_back(mk(31)); sb.push_back(mk(31)); sb.push_back(mk(31));
        bs = strb_cnt;
        chan_mask = 32'h8000_0000;
        run = 1'b1;
        wait_strb(bs + 1, 500);
        exp_gap = 49;
        wait_strb(bs + 2, 500);
        drop_run();
        wait_idle(500);
        exp_gap = 0;
        check("single_strobe_count", 32'(strb_cnt - bs), 3);

        // Channel 3 never answers; channel 4 still strobes.
        sb.push_back(mk(4)); sb.push_back(mk(4));
        bs = strb_cnt;
        bt = to_cnt;
        dead_ch = 3;
        chan_mask = 32'h0000_0018;
        run = 1'b1;
        wait_to(bt + 2, 3000);
        drop_run();
        wait_idle(500);
        check("tmo_strobe_count", 32'(strb_cnt - bs), 2);
        check("tmo_count", 32'(to_cnt - bt), 2);
        dead_ch = -1;

        // run dropped two cycles after the first start of channel 1.
        sb.push_back(mk(1));
        bs = strb_cnt;
        bst = start_cnt;
        chan_mask = 32'h0000_0002;
        run = 1'b1;
        wait_start(bst + 1, 200);
        repeat (2) @(negedge wb_clk_i);
        run = 1'b0;
        wait_idle(500);
        check("rundrop_strobe_count", 32'(strb_cnt - bs), 1);
        bst = start_cnt;
        repeat (100) @(negedge wb_clk_i);
        check("rundrop_no_start", 32'(start_cnt - bst), 0);
        check("held_channel", 32'(adc_channel), 1);
        check("held_result", 32'(adc_result), 32'h111);

        // Mask cleared while channel 5 settles: it finishes, then the search wraps to idle.
        sb.push_back(mk(5));
        bs = strb_cnt;
        chan_mask = 32'h0000_0020;
        run = 1'b1;
        for (int i = 0; i < 200 && adc_chsel_o != 5'd5; i++) @(negedge wb_clk_i);
        check("mask_clr_chsel", 32'(adc_chsel_o), 5);
        chan_mask = '0;
        wait_idle(500);
        check("mask_clr_strobe_count", 32'(strb_cnt - bs), 1);
        bst = start_cnt;
        repeat (100) @(negedge wb_clk_i);
        check("mask_clr_no_start", 32'(start_cnt - bst), 0);
        check("mask_clr_idle", 32'(seq_busy), 0);
        run = 1'b0;

        // Reset while waiting on a conversion of channel 1.
        bst = start_cnt;
        chan_mask = 32'h0000_0006;
        run = 1'b1;
        wait_start(bst + 1, 200);
        check("pre_reset_chsel", 32'(adc_chsel_o), 1);
        repeat (5) @(negedge wb_clk_i);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) @(negedge wb_clk_i);
        sb.push_back(mk(1)); sb.push_back(mk(2));
        bs = strb_cnt;
        wb_rst_n_i = 1'b1;
        wait_strb(bs + 1, 500);
        drop_run();
        wait_idle(500);
        check("post_reset_strobe_count", 32'(strb_cnt - bs), 2);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
